// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one registered ALU between NUM_REQ requesters. Requests are
//   arbitrated round-robin; exactly one operation is in flight at a time.
//   The arbiter registers the winning operands/func toward the ALU, waits
//   ALU_LATENCY cycles, captures the result/flags, and presents them to the
//   owning requester until that requester accepts the response.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester request handshake (ready is one-hot or 0)
//   req_a/b/func      : packed per-requester operands (32b) and func (6b)
//   resp_valid/ready  : per-requester response handshake (valid one-hot to owner)
//   resp_result/flags : shared response bus, held while resp_valid is set
//   alu_operand_a/b   : registered operands to the ALU
//   alu_func          : registered func code to the ALU
//   alu_result/flags  : ALU outputs
//   busy              : high whenever an operation is outstanding
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*6-1:0]   req_func,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_result,
  output logic [3:0]             resp_flags,
  output logic [31:0]            alu_operand_a,
  output logic [31:0]            alu_operand_b,
  output logic [5:0]             alu_func,
  input  logic [31:0]            alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   busy
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        op_a_d, op_b_d, result_d;
  logic [5:0]         func_d;
  logic [3:0]         flags_d;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [31:0]        sel_a, sel_b;
  logic [5:0]         sel_func;
  logic               owner_ready;

  // Round-robin search: first valid requester at or above the pointer,
  // wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Payload of the current winner and response-ready of the current owner.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_func    = '0;
    owner_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
        sel_func = req_func[6*i +: 6];
      end
      if (owner_q == IDX_W'(i)) begin
        owner_ready = resp_ready[i];
      end
    end
  end

  // Handshake outputs. req_ready is masked during reset so no requester
  // believes its request was consumed by a cycle that reset discards.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = (state_q == IDLE) && !rst && grant_found &&
                      (grant_idx == IDX_W'(i));
      resp_valid[i] = (state_q == RESP) && (owner_q == IDX_W'(i));
    end
    busy = (state_q != IDLE);
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    op_a_d   = alu_operand_a;
    op_b_d   = alu_operand_b;
    func_d   = alu_func;
    result_d = resp_result;
    flags_d  = resp_flags;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          func_d  = sel_func;
          owner_d = grant_idx;
          ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d   = CNT_W'(ALU_LATENCY);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_result;
          flags_d  = alu_flags;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_func      <= '0;
      resp_result   <= '0;
      resp_flags    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      alu_operand_a <= op_a_d;
      alu_operand_b <= op_b_d;
      alu_func      <= func_d;
      resp_result   <= result_d;
      resp_flags    <= flags_d;
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered ALU instance (`alu`, driven by `func` codes from alu.svh) between NUM_REQ requesters.
- Requesters use a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- Sits between the decode/issue units and the ALU; it is the only driver of the ALU operand and func inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ALU_LATENCY, 1, cycles from ALU inputs valid to ALU result valid (1..4)
IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept; at most one bit set
req_a  in  NUM_REQ*32  operand A; requester i at bits [32i+31:32i]
req_b  in  NUM_REQ*32  operand B, same packing as req_a
req_func  in  NUM_REQ*6  ALU func code; requester i at bits [6i+5:6i]
resp_valid  out  NUM_REQ  response valid; one-hot to the owning requester
resp_ready  in  NUM_REQ  per-requester response accept
resp_result  out  32  shared result bus, meaningful when any resp_valid bit is set
resp_flags  out  4  shared flags bus, captured with resp_result
alu_operand_a  out  32  to ALU operand_a (registered)
alu_operand_b  out  32  to ALU operand_b (registered)
alu_func  out  6  to ALU func (registered)
alu_result  in  32  from ALU result
alu_flags  in  4  from ALU flags
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, synchronous, overrides everything:
  - State goes to IDLE; priority pointer = 0.
  - req_ready, resp_valid, busy = 0.
  - alu_operand_a, alu_operand_b, alu_func, resp_result, resp_flags = 0.
  - An operation in flight is discarded and no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g = first i with req_valid[i] set, scanning from the pointer upward modulo NUM_REQ.
  - req_ready[g] = 1, combinational from req_valid and the pointer. All other bits are 0. If no request is valid, req_ready = 0.
  - When req_valid[g] && req_ready[g]:
    - Register req_a/req_b/req_func slice g into alu_operand_a/b/func.
    - Store g as the owner.
    - Set pointer = (g+1) mod NUM_REQ.
    - Load the wait counter with ALU_LATENCY and go to EXEC.
- EXEC:
  - req_ready = 0.
  - ALU inputs are held stable.
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 1, capture alu_result/alu_flags into resp_result/resp_flags and go to RESP.
- RESP:
  - resp_valid[owner] = 1; resp_result and resp_flags are held stable.
  - On resp_ready[owner] = 1, go to IDLE; resp_valid drops in the next cycle.
  - resp_ready bits of non-owners are ignored.
- Latency:
  - Request accepted in cycle T → resp_valid high in cycle T+1+ALU_LATENCY.
  - Default is 2 cycles after acceptance.
  - A new acceptance is possible at the earliest in the cycle after the response handshake.
  - Minimum issue interval is ALU_LATENCY+2 cycles.
- Requests that are not granted are not consumed. A requester must hold req_valid and its payload until it sees req_ready.
- req_valid deasserted in IDLE before grant: no effect; arbitration is re-evaluated every cycle.
- Pointer wraps from NUM_REQ-1 to 0. The pointer advances only on acceptance.
- Arithmetic: the arbiter never modifies operands; all width and overflow behaviour belongs to the ALU.
- busy = (state != IDLE).

Test Plan:
- Single requester 0:
  - Stimulus: a=100, b=75, `func_add`.
  - Required: req_ready[0] in the same cycle; resp_valid[0] 2 cycles after acceptance with resp_result=175.
  - Stimulus: 9999 `func_sub` -999.
  - Required: resp_result=10998.
- Contention:
  - Stimulus: all 4 req_valid held high from reset, each with a distinct add (1+1, 2+2, 3+3, 4+4); resp_ready tied high.
  - Required: grants in order 0,1,2,3; results 2,4,6,8 on resp_valid[0..3] respectively; each issue 3 cycles apart.
- Fairness:
  - Stimulus: grant requester 2, then raise req_valid[0] and req_valid[3] together.
  - Required: requester 3 is granted before requester 0.
- Response backpressure:
  - Stimulus: resp_ready[1] held low for 5 cycles with the response 7 `func_sub` 7 pending.
  - Required: resp_valid[1]=1 and resp_result=0 stay stable; req_ready stays 0 for all requesters, even with other req_valid high; completes on the first cycle resp_ready[1]=1.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC.
  - Required: next cycle busy=0, resp_valid=0, pointer=0; no response is ever delivered for the aborted op; the next request from requester 0 completes normally.
- Wrong-owner ready:
  - Stimulus: in RESP for owner 2, pulse resp_ready[0].
  - Required: no state change; resp_valid[2] stays high.
